// File: rtl/meu_fourbits_adder.sv
// 4-bit ripple-carry adder with carry-in, carry-out and signed overflow.
// The result is registered: one result per valid input, one clock of latency.
module meu_fourbits_adder (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       carry_i,
  input  logic       valid_i,
  output logic [3:0] sum_o,
  output logic       carry_o,
  output logic       overflow_o,
  output logic       valid_o
);

  logic [4:0] c;
  logic [3:0] s;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = carry_i;
    for (int k = 0; k < 4; k++) begin
      s[k]   = a_i[k] ^ b_i[k] ^ c[k];
      c[k+1] = (a_i[k] & b_i[k]) | (c[k] & (a_i[k] ^ b_i[k]));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sum_o      <= '0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
      valid_o    <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        sum_o      <= s;
        carry_o    <= c[4];
        overflow_o <= c[3] ^ c[4];
      end
    end
  end

endmodule

// File: tb/tb_meu_fourbits_adder.sv
// Scoreboard bench for meu_fourbits_adder: stimulus pushes expected results,
// a negedge monitor pops and compares whenever valid_o is presented.
module tb_meu_fourbits_adder;

  typedef struct packed {
    logic [3:0] sum;
    logic       carry;
    logic       ovf;
  } result_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       cin = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] sum;
  logic       carry;
  logic       ovf;
  logic       valid_out;

  int      total = 0;
  int      bad = 0;
  result_t exp_q[$];
  result_t last_exp = '0;

  always #5 clk = ~clk;

  meu_fourbits_adder dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .a_i        (a),
    .b_i        (b),
    .carry_i    (cin),
    .valid_i    (valid),
    .sum_o      (sum),
    .carry_o    (carry),
    .overflow_o (ovf),
    .valid_o    (valid_out)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference model: plain unsigned and signed arithmetic on the operands.
  function automatic result_t model(input int av, input int bv, input int cv);
    result_t r;
    int      u;
    int      sv;
    u  = av + bv + cv;
    sv = (av > 7 ? av - 16 : av) + (bv > 7 ? bv - 16 : bv) + cv;
    r.sum   = 4'(u % 16);
    r.carry = (u >= 16);
    r.ovf   = (sv > 7) || (sv < -8);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          result_t e;
          e = exp_q.pop_front();
          check("sum", int'(sum), int'(e.sum));
          check("carry", int'(carry), int'(e.carry));
          check("overflow", int'(ovf), int'(e.ovf));
        end
      end else if (exp_q.size() != 0) begin
        check("missing_valid", int'(valid_out), 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic issue(input int av, input int bv, input int cv);
    a     = 4'(av);
    b     = 4'(bv);
    cin   = cv[0];
    valid = 1'b1;
    @(posedge clk);
    last_exp = model(av, bv, cv);
    exp_q.push_back(last_exp);
    #1;
  endtask

  task automatic idle_cycle(input string name);
    valid = 1'b0;
    a     = 4'($urandom_range(0, 15));
    b     = 4'($urandom_range(0, 15));
    cin   = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    check({name, "_valid"}, int'(valid_out), 0);
    check({name, "_sum"}, int'(sum), int'(last_exp.sum));
    check({name, "_carry"}, int'(carry), int'(last_exp.carry));
    check({name, "_ovf"}, int'(ovf), int'(last_exp.ovf));
  endtask

  task automatic check_zero(input string name);
    check({name, "_sum"}, int'(sum), 0);
    check({name, "_carry"}, int'(carry), 0);
    check({name, "_ovf"}, int'(ovf), 0);
    check({name, "_valid"}, int'(valid_out), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with max operands and valid asserted: nothing may be captured.
    rst_n = 1'b0;
    a = 4'd15; b = 4'd15; cin = 1'b1; valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(0, 0, 0);
    issue(1, 0, 0);
    issue(15, 1, 0);
    issue(1, 1, 0);
    issue(15, 15, 0);
    issue(15, 15, 1);
    issue(7, 1, 0);
    issue(8, 8, 0);

    repeat (3) idle_cycle("hold");

    for (int i = 0; i < 512; i++) issue(i % 16, (i / 16) % 16, i / 256);

    repeat (2) idle_cycle("hold2");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle("gap");
      else issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
    end

    // Mid-stream reset: the issued operands are dropped and outputs clear at once.
    issue(9, 9, 1);
    @(negedge clk);
    #1;
    a = 4'd15; b = 4'd15; cin = 1'b1; valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #1;
    check_zero("reset_pending");
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = '0;
    idle_cycle("post_reset");

    issue(15, 1, 0);
    issue(3, 4, 1);
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
